qar_mem_arbiter: RTL and testbench

Two-port to one-port memory arbiter. It lets `qar_core`'s instruction-fetch port (`imem_*`) and data port (`mem_*`) share a single external memory interface. Data accesses normally win ties, and a starvation counter guarantees fetch progress. A per-transaction timeout converts a hung downstream access into a bus-error completion. It sits between the core's two memory ports and a unified RAM/bus.

---
 rtl/qar_bus_pkg.sv | 25 ++
 rtl/qar_arb_timeout.sv | 56 +++++
 rtl/qar_mem_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_qar_mem_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/qar_bus_pkg.sv
// ---------------------------------------------------------------------------
// qar_bus_pkg
// Shared definitions for the qar memory-side bus: arbiter state encoding,
// owner codes reported on the arbiter's owner port, and the data width used
// by every handshake in the memory path.
// ---------------------------------------------------------------------------
package qar_bus_pkg;

  // Width of every read/write data word on the core and memory sides.
  localparam int DATA_WIDTH = 32;

  // Arbiter FSM states. The BUSY encodings match the owner codes on purpose,
  // so the owner port is a direct image of the state register.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } arb_state_e;

  // Owner codes driven on the owner port.
  localparam logic [1:0] OWNER_NONE  = 2'd0;
  localparam logic [1:0] OWNER_FETCH = 2'd1;
  localparam logic [1:0] OWNER_DATA  = 2'd2;

endpackage

// File: rtl/qar_arb_timeout.sv
// ---------------------------------------------------------------------------
// qar_arb_timeout
// Loadable down-counter that flags a downstream access stuck for
// TIMEOUT_CYCLES cycles. TIMEOUT_CYCLES = 0 removes the counter and the
// flag never rises.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   load_i     in   reload the counter (held while the arbiter is idle)
//   en_i       in   count one stalled cycle
//   expired_o  out  counter has reached its final stalled cycle
// ---------------------------------------------------------------------------
module qar_arb_timeout #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_disabled
      assign expired_o = 1'b0;
    end else begin : g_enabled
      localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
      localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYCLES - 1);

      logic [CW-1:0] cnt_q, cnt_d;

      // Loading with TIMEOUT_CYCLES-1 makes zero line up with the last
      // allowed stalled cycle, so the flag is a plain zero compare.
      always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
          cnt_d = LOAD_VAL;
        end else if (en_i && (cnt_q != '0)) begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign expired_o = (cnt_q == '0);
    end
  endgenerate

endmodule

// File: rtl/qar_mem_arbiter.sv
// ---------------------------------------------------------------------------
// qar_mem_arbiter
// Shares one external memory port between the core's instruction-fetch port
// (i_*) and data port (d_*). Data wins ties until the fetch side has been
// passed over STARVE_LIMIT times in a row. A stuck downstream access is
// completed with zero data and a bus_err pulse after TIMEOUT_CYCLES cycles.
//
// Ports:
//   clk, rst_n                  clock / synchronous active-low reset
//   i_valid, i_addr             fetch request (held until i_ready)
//   i_ready, i_rdata            fetch completion strobe and data
//   d_valid, d_we, d_addr,
//   d_wdata                     data request (held until d_ready)
//   d_ready, d_rdata            data completion strobe and load data
//   m_valid, m_we, m_addr,
//   m_wdata                     registered downstream request
//   m_ready, m_rdata            downstream completion and read data
//   bus_err                     one-cycle pulse on a timed-out completion
//   owner                       0 none, 1 fetch, 2 data
// ---------------------------------------------------------------------------
module qar_mem_arbiter
  import qar_bus_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_ready,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_valid,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ready,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  m_valid,
  output logic                  m_we,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic                  m_ready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  output logic                  bus_err,
  output logic [1:0]            owner
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_e            state_q, state_d;
  logic [SW-1:0]         starve_q, starve_d;
  logic                  m_valid_q, m_valid_d;
  logic                  m_we_q, m_we_d;
  logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
  logic [DATA_WIDTH-1:0] m_wdata_q, m_wdata_d;
  logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;

  logic                  busy;
  logic                  expired;
  logic                  xfer_done;
  logic                  grant_i;
  logic                  grant_d;
  logic [DATA_WIDTH-1:0] done_rdata;

  assign busy = (state_q != ST_IDLE);

  qar_arb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (!busy),
    .en_i     (busy && !m_ready),
    .expired_o(expired)
  );

  // A transaction ends on m_ready or on expiry. rst_n gates it so a reset
  // landing mid-transaction never emits a ready or bus_err.
  assign xfer_done = busy && rst_n && (m_ready || expired);

  // Arbitration: data wins unless fetch has been passed over STARVE_LIMIT
  // times in a row while waiting.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_q == ST_IDLE) begin
      if (d_valid && (!i_valid || (starve_q < STARVE_MAX))) begin
        grant_d = 1'b1;
      end else if (i_valid) begin
        grant_i = 1'b1;
      end
    end
  end

  // Completion strobes and read data. m_ready has priority over expiry, so
  // bus_err only fires when the memory never answered.
  always_comb begin
    done_rdata = m_ready ? m_rdata : '0;
    i_ready    = 1'b0;
    d_ready    = 1'b0;
    bus_err    = 1'b0;
    if (xfer_done) begin
      bus_err = !m_ready;
      if (state_q == ST_BUSY_I) begin
        i_ready = 1'b1;
      end else begin
        d_ready = 1'b1;
      end
    end
    i_rdata   = i_ready ? done_rdata : i_rdata_q;
    d_rdata   = d_ready ? done_rdata : d_rdata_q;
    i_rdata_d = i_rdata;
    d_rdata_d = d_rdata;
  end

  // Next-state logic: capture the winner's request on the grant edge, hold
  // it through BUSY, release on completion.
  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    m_valid_d = m_valid_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_d) begin
          state_d   = ST_BUSY_D;
          m_valid_d = 1'b1;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          if (!i_valid) begin
            starve_d = '0;
          end else if (starve_q != STARVE_MAX) begin
            starve_d = starve_q + SW'(1);
          end
        end else if (grant_i) begin
          state_d   = ST_BUSY_I;
          m_valid_d = 1'b1;
          m_we_d    = 1'b0;
          m_addr_d  = i_addr;
          m_wdata_d = '0;
          starve_d  = '0;
        end else if (!i_valid) begin
          starve_d = '0;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        if (xfer_done) begin
          state_d   = ST_IDLE;
          m_valid_d = 1'b0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        m_valid_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      starve_q  <= '0;
      m_valid_q <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      m_valid_q <= m_valid_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign owner   = (state_q == ST_BUSY_I) ? OWNER_FETCH :
                   (state_q == ST_BUSY_D) ? OWNER_DATA  : OWNER_NONE;

endmodule

// File: tb/tb_qar_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_qar_mem_arbiter
// Directed bench for qar_mem_arbiter (STARVE_LIMIT=4, TIMEOUT_CYCLES=8)
// against a small word memory with programmable wait states and a hang mode.
// ---------------------------------------------------------------------------
module tb_qar_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid, d_valid, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_ready, d_ready;
  logic [31:0] i_rdata, d_rdata;
  logic        m_valid, m_we, m_ready;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        bus_err;
  logic [1:0]  owner;

  int cmpCount = 0;
  int errCount = 0;

  logic [31:0] mem [0:255];
  int          waitStates = 0;
  logic        hang = 1'b0;
  int          wcnt = 0;

  int expOwner [10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};

  qar_mem_arbiter #(
    .ADDR_WIDTH(32),
    .STARVE_LIMIT(4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_valid(d_valid), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .m_valid(m_valid), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata),
    .bus_err(bus_err), .owner(owner)
  );

  always #5 clk = ~clk;

  // Memory model: answers after waitStates stalled cycles, never when hung.
  assign m_ready = m_valid && !hang && (wcnt == waitStates);
  assign m_rdata = mem[m_addr[9:2]];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 256; k++) mem[k] <= 32'h0;
      mem[4]  <= 32'h0010_0093;
      mem[9]  <= 32'h1234_5678;
      mem[16] <= 32'h0000_0013;
      mem[17] <= 32'hA5A5_A5A5;
      wcnt    <= 0;
    end else begin
      if (m_valid && m_ready && m_we) mem[m_addr[9:2]] <= m_wdata;
      if (m_valid && !m_ready) wcnt <= wcnt + 1;
      else wcnt <= 0;
    end
  end

  task automatic applyStimulus(input logic iv, input logic [31:0] ia,
                               input logic dv, input logic dwe,
                               input logic [31:0] da, input logic [31:0] dwd);
    i_valid = iv;
    i_addr  = ia;
    d_valid = dv;
    d_we    = dwe;
    d_addr  = da;
    d_wdata = dwd;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    cmpCount++;
    assert (observed === expected) else begin
      errCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_m_valid", 32'(m_valid), 32'h0);
    checkOutput("rst_m_we", 32'(m_we), 32'h0);
    checkOutput("rst_m_addr", m_addr, 32'h0);
    checkOutput("rst_m_wdata", m_wdata, 32'h0);
    checkOutput("rst_i_ready", 32'(i_ready), 32'h0);
    checkOutput("rst_d_ready", 32'(d_ready), 32'h0);
    checkOutput("rst_bus_err", 32'(bus_err), 32'h0);
    checkOutput("rst_owner", 32'(owner), 32'h0);
    checkOutput("rst_i_rdata", i_rdata, 32'h0);
    checkOutput("rst_d_rdata", d_rdata, 32'h0);

    $display("[TB] fetch only");
    rst_n = 1'b1;
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("fetch_req_cycle_m_valid", 32'(m_valid), 32'h0);
    @(negedge clk); #1;
    checkOutput("fetch_m_valid", 32'(m_valid), 32'h1);
    checkOutput("fetch_owner", 32'(owner), 32'h1);
    checkOutput("fetch_m_addr", m_addr, 32'h10);
    checkOutput("fetch_m_we", 32'(m_we), 32'h0);
    checkOutput("fetch_i_ready", 32'(i_ready), 32'h1);
    checkOutput("fetch_i_rdata", i_rdata, 32'h0010_0093);
    checkOutput("fetch_d_ready", 32'(d_ready), 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk); #1;
    checkOutput("fetch_after_owner", 32'(owner), 32'h0);
    checkOutput("fetch_after_m_valid", 32'(m_valid), 32'h0);
    checkOutput("fetch_after_i_ready", 32'(i_ready), 32'h0);
    checkOutput("fetch_hold_i_rdata", i_rdata, 32'h0010_0093);

    $display("[TB] starvation");
    applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 32'h44, 32'h0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      checkOutput($sformatf("starve_owner_%0d", k), 32'(owner), 32'(expOwner[k]));
      checkOutput($sformatf("starve_ready_%0d", k), 32'({i_ready, d_ready}),
                  (expOwner[k] == 1) ? 32'h2 : 32'h1);
      @(negedge clk);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);

    $display("[TB] write with 3 wait states");
    waitStates = 3;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk); #1;
      checkOutput($sformatf("wr_m_we_%0d", c), 32'(m_we), 32'h1);
      checkOutput($sformatf("wr_m_addr_%0d", c), m_addr, 32'h20);
      checkOutput($sformatf("wr_m_wdata_%0d", c), m_wdata, 32'hDEAD_BEEF);
      checkOutput($sformatf("wr_d_ready_%0d", c), 32'(d_ready), (c == 4) ? 32'h1 : 32'h0);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk); #1;
    checkOutput("wr_after_m_valid", 32'(m_valid), 32'h0);
    checkOutput("wr_mem_word", mem[8], 32'hDEAD_BEEF);

    $display("[TB] timeout");
    waitStates = 0;
    hang = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk); #1;
      checkOutput($sformatf("to_d_ready_%0d", c), 32'(d_ready), (c == 8) ? 32'h1 : 32'h0);
      checkOutput($sformatf("to_bus_err_%0d", c), 32'(bus_err), (c == 8) ? 32'h1 : 32'h0);
      if (c == 8) checkOutput("to_d_rdata", d_rdata, 32'h0);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    hang = 1'b0;
    @(negedge clk); #1;
    checkOutput("to_after_m_valid", 32'(m_valid), 32'h0);
    checkOutput("to_after_bus_err", 32'(bus_err), 32'h0);
    checkOutput("to_hold_d_rdata", d_rdata, 32'h0);
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk); #1;
    checkOutput("to_fetch_i_ready", 32'(i_ready), 32'h1);
    checkOutput("to_fetch_i_rdata", i_rdata, 32'h0010_0093);
    checkOutput("to_fetch_bus_err", 32'(bus_err), 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);

    $display("[TB] timeout boundary");
    waitStates = 7;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h24, 32'h0);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk); #1;
      checkOutput($sformatf("tb_d_ready_%0d", c), 32'(d_ready), (c == 8) ? 32'h1 : 32'h0);
      checkOutput($sformatf("tb_bus_err_%0d", c), 32'(bus_err), 32'h0);
      if (c == 8) checkOutput("tb_d_rdata", d_rdata, 32'h1234_5678);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk); #1;
    checkOutput("tb_after_m_valid", 32'(m_valid), 32'h0);

    $display("[TB] reset mid-op");
    waitStates = 3;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h24, 32'h0);
    @(negedge clk); #1;
    checkOutput("rmo_owner_busy", 32'(owner), 32'h2);
    @(negedge clk); #1;
    rst_n = 1'b0;
    waitStates = 0;
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("rmo_rst_cycle_d_ready", 32'(d_ready), 32'h0);
    checkOutput("rmo_rst_cycle_bus_err", 32'(bus_err), 32'h0);
    @(negedge clk); #1;
    checkOutput("rmo_m_valid", 32'(m_valid), 32'h0);
    checkOutput("rmo_owner", 32'(owner), 32'h0);
    checkOutput("rmo_m_addr", m_addr, 32'h0);
    checkOutput("rmo_d_rdata", d_rdata, 32'h0);
    checkOutput("rmo_i_rdata", i_rdata, 32'h0);
    checkOutput("rmo_bus_err", 32'(bus_err), 32'h0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    checkOutput("rmo_fetch_owner", 32'(owner), 32'h1);
    checkOutput("rmo_fetch_i_ready", 32'(i_ready), 32'h1);
    checkOutput("rmo_fetch_i_rdata", i_rdata, 32'h0010_0093);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule
